// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath it sequences.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] alucontrol;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, Zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               alucontrol, PCSrc, PCEn, illegal, state
    );

    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               alucontrol, PCSrc, PCEn, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle MIPS datapath with shared memory and a single ALU.
// Moore outputs per state; PCEn and the FETCH write enables also see Zero / mem_ready.
module multicycle_controller #(
    parameter bit ERR_HALT = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StError   = 4'd15
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, funct_q;
    logic       funct_ok;
    logic [1:0] aluop;
    logic       pc_write;
    logic       branch;
    logic       mem_write_raw, ir_write_raw, reg_write_raw;

    // Instruction fields are captured only in DECODE so later edits are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                opcode_q <= bus.opcode;
                funct_q  <= bus.funct;
            end
        end
    end

    always_comb begin
        funct_ok = 1'b0;
        case (bus.funct)
            FnAdd, FnSub, FnAnd, FnOr, FnSlt: funct_ok = 1'b1;
            default:                          funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpRtype:    state_d = funct_ok ? StExecute : StError;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StError;
                endcase
            end
            StMemAdr:  state_d = (opcode_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (bus.mem_ready) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   if (bus.mem_ready) state_d = StFetch;
            StExecute: state_d = StAluWb;
            StAluWb:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            StAddiEx:  state_d = StAddiWb;
            StAddiWb:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StError:   state_d = ERR_HALT ? StError : StFetch;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        bus.IorD      = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.PCSrc     = 2'b00;
        aluop         = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        case (state_q)
            StFetch: begin
                bus.ALUSrcB  = 2'b01;
                ir_write_raw = bus.mem_ready;
                pc_write     = bus.mem_ready;
            end
            StDecode:  bus.ALUSrcB = 2'b11;
            StMemAdr: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            StMemRd:   bus.IorD = 1'b1;
            StMemWb: begin
                bus.MemtoReg  = 1'b1;
                reg_write_raw = 1'b1;
            end
            // Write strobe is held for the whole access; it commits when mem_ready rises.
            StMemWr: begin
                bus.IorD      = 1'b1;
                mem_write_raw = 1'b1;
            end
            StExecute: begin
                bus.ALUSrcA = 1'b1;
                aluop       = 2'b10;
            end
            StAluWb: begin
                bus.RegDst    = 1'b1;
                reg_write_raw = 1'b1;
            end
            StBranch: begin
                bus.ALUSrcA = 1'b1;
                aluop       = 2'b01;
                bus.PCSrc   = 2'b01;
                branch      = 1'b1;
            end
            StAddiEx: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            StAddiWb:  reg_write_raw = 1'b1;
            StJump: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase

        bus.MemWrite = mem_write_raw & ~reset;
        bus.IRWrite  = ir_write_raw & ~reset;
        bus.RegWrite = reg_write_raw & ~reset;
        bus.PCEn     = (pc_write | (branch & bus.Zero)) & ~reset;
        bus.illegal  = (state_q == StError);
        bus.state    = state_q;
    end

    // Same ALUOp encoding as the single-cycle control unit.
    always_comb begin
        bus.alucontrol = 3'b010;
        case (aluop)
            2'b01: bus.alucontrol = 3'b110;
            2'b10: begin
                case (funct_q)
                    FnAdd:   bus.alucontrol = 3'b010;
                    FnSub:   bus.alucontrol = 3'b110;
                    FnAnd:   bus.alucontrol = 3'b000;
                    FnOr:    bus.alucontrol = 3'b001;
                    FnSlt:   bus.alucontrol = 3'b111;
                    default: bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end

endmodule
